// File: rtl/instruction_memory.sv
// Word-organised instruction memory: combinational byte-addressed read port,
// clocked byte-maskable write port, synchronous reset back to the boot image.
module instruction_memory #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       instruction,
  output logic              misaligned,
  output logic              out_of_range,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb
);

  localparam int IDX_W = $clog2(DEPTH);

  // The array holds the XOR difference from the boot image, so an all-zero
  // array (time zero or after reset) reads back exactly the boot program.
  logic [31:0] r_delta [DEPTH] = '{default: '0};

  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic             w_rd_in_range;
  logic             w_wr_in_range;
  logic [31:0]      w_cur_word;
  logic [31:0]      w_new_word;
  logic             w_unused;

  function automatic logic [31:0] boot_word(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(0): boot_word = 32'h00500093;
      IDX_W'(1): boot_word = 32'h00300113;
      IDX_W'(2): boot_word = 32'h002081B3;
      default:   boot_word = NOP_WORD;
    endcase
  endfunction

  assign w_ridx        = addr[IDX_W+1:2];
  assign w_widx        = waddr[IDX_W+1:2];
  assign w_rd_in_range = ~|addr[ADDR_W-1:IDX_W+2];
  assign w_wr_in_range = ~|waddr[ADDR_W-1:IDX_W+2];
  assign w_unused      = &{1'b0, waddr[1:0]};

  assign misaligned   = |addr[1:0];
  assign out_of_range = ~w_rd_in_range;
  assign instruction  = w_rd_in_range ? (boot_word(w_ridx) ^ r_delta[w_ridx]) : NOP_WORD;

  always_comb begin
    w_cur_word = boot_word(w_widx) ^ r_delta[w_widx];
    w_new_word = w_cur_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        w_new_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_delta[i] <= '0;
      end
    end else if (we && w_wr_in_range) begin
      r_delta[w_widx] <= w_new_word ^ boot_word(w_widx);
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: table-driven boot reads plus
// hand-written write/reset sequences, compared through an expectation queue.
module tb_instruction_memory;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] instruction;
  logic        misaligned;
  logic        out_of_range;
  logic        we = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] instr;
    logic        mis;
    logic        oor;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[9];

  instruction_memory #(.DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .addr(addr), .instruction(instruction),
    .misaligned(misaligned), .out_of_range(out_of_range),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
  );

  // First edge is delayed so the boot reads happen with no clock edge seen.
  initial begin
    #50;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] boot_val(input int idx);
    case (idx)
      0:       boot_val = 32'h00500093;
      1:       boot_val = 32'h00300113;
      2:       boot_val = 32'h002081B3;
      default: boot_val = NOP;
    endcase
  endfunction

  task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] ei,
                            input logic em, input logic eo);
    vec_t v;
    vec_t e;
    v.name = nm; v.a = a; v.instr = ei; v.mis = em; v.oor = eo;
    addr = a;
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (instruction !== e.instr || misaligned !== e.mis || out_of_range !== e.oor) begin
      failures++;
      $display("FAIL %s addr=%h: got instr=%h mis=%b oor=%b, expected instr=%h mis=%b oor=%b",
               e.name, e.a, instruction, misaligned, out_of_range, e.instr, e.mis, e.oor);
    end
  endtask

  task automatic write_edge(input logic r, input logic w, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [3:0] ws);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; wstrb = ws;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; wstrb = '0;
  endtask

  initial begin
    vecs[0] = '{"boot_w0",   32'd0,         32'h00500093, 1'b0, 1'b0};
    vecs[1] = '{"boot_w1",   32'd4,         32'h00300113, 1'b0, 1'b0};
    vecs[2] = '{"boot_w2",   32'd8,         32'h002081B3, 1'b0, 1'b0};
    vecs[3] = '{"fill_w3",   32'd12,        NOP,          1'b0, 1'b0};
    vecs[4] = '{"last_w63",  32'd252,       NOP,          1'b0, 1'b0};
    vecs[5] = '{"oor_256",   32'd256,       NOP,          1'b0, 1'b1};
    vecs[6] = '{"mis_255",   32'd255,       NOP,          1'b1, 1'b0};
    vecs[7] = '{"mis_6",     32'd6,         32'h00300113, 1'b1, 1'b0};
    vecs[8] = '{"oor_high",  32'hFFFF_FFFD, NOP,          1'b1, 1'b1};

    for (int i = 0; i < 9; i++)
      read_check(vecs[i].name, vecs[i].a, vecs[i].instr, vecs[i].mis, vecs[i].oor);

    // Byte-masked write to word 2: old value before the edge, merged after.
    @(negedge clk);
    we = 1'b1; waddr = 32'd8; wdata = 32'hDEADBEEF; wstrb = 4'b0101;
    read_check("raw_before", 32'd8, 32'h002081B3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    we = 1'b0; wstrb = '0;
    read_check("raw_after", 32'd8, 32'h00AD81EF, 1'b0, 1'b0);

    // Write with all strobes clear changes nothing; waddr[1:0] ignored.
    write_edge(1'b0, 1'b1, 32'd14, 32'hCAFEF00D, 4'b0000);
    read_check("wstrb_zero", 32'd12, NOP, 1'b0, 1'b0);
    write_edge(1'b0, 1'b1, 32'd23, 32'h12345678, 4'b1111);
    read_check("full_w5", 32'd20, 32'h12345678, 1'b0, 1'b0);
    write_edge(1'b0, 1'b1, 32'd20, 32'hAABBCCDD, 4'b1000);
    read_check("hi_lane_w5", 32'd20, 32'hAA345678, 1'b0, 1'b0);

    // Reset raised between edges has no effect until the next edge.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 32'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    read_check("rst_pending", 32'd8, 32'h00AD81EF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; wstrb = '0;
    read_check("rst_prio_w0", 32'd0, 32'h00500093, 1'b0, 1'b0);
    read_check("rst_restore_w2", 32'd8, 32'h002081B3, 1'b0, 1'b0);
    read_check("rst_restore_w5", 32'd20, NOP, 1'b0, 1'b0);

    // Out-of-range writes, including one that would alias if truncated.
    write_edge(1'b0, 1'b1, 32'd256, 32'h12345678, 4'hF);
    write_edge(1'b0, 1'b1, 32'h8000_0000, 32'h87654321, 4'hF);
    write_edge(1'b0, 1'b1, 32'h0000_0104, 32'h11111111, 4'hF);
    for (int i = 0; i < DEPTH; i++)
      read_check($sformatf("oor_wr_w%0d", i), 32'(i * 4), boot_val(i), 1'b0, 1'b0);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
